// File: rtl/hamming74_serial_rx.sv
// Serial Hamming(7,4) receiver: deserialises sync-delimited codewords, corrects single-bit errors,
// buffers decoded nibbles in a FIFO and keeps link error statistics. Optional SECDED: HAMMING74_RX_SECDED_EN.
module hamming74_serial_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sync_in,
  output logic [3:0]       data_out,
  output logic [3:0]       raw_out,
  output logic             err_flag,
  output logic             dbl_err,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CNT_W-1:0] err_count,
  output logic             overflow,
  output logic             frame_err,
  input  logic             clr_stats,
  output logic             busy
);

`ifdef HAMMING74_RX_SECDED_EN
  localparam int FW = 8;
`else
  localparam int FW = 7;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 10;

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t              state_q;
  logic [FW-1:0]       sr_q;
  logic [3:0]          cnt_q;
  logic                frame_err_q;
  logic [CNT_W-1:0]    err_cnt_q;
  logic                ovf_q;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_q;
  logic [AW:0]         rd_ptr_q;

  logic [6:0]          cw;
  logic [2:0]          syn;
  logic [3:0]          raw_d;
  logic [3:0]          fix_d;
  logic [3:0]          dec_d;
  logic                err_d;
  logic                dbl_d;
  logic [EW-1:0]       entry_d;
  logic [EW-1:0]       head;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                wr_en;

  // The seven Hamming bits sit at the top of the shift register; c7 (if any) is the last bit in.
  always_comb begin
    cw     = sr_q[FW-1 -: 7];
    syn[0] = cw[0] ^ cw[6] ^ cw[4] ^ cw[2];
    syn[1] = cw[1] ^ cw[6] ^ cw[5] ^ cw[2];
    syn[2] = cw[3] ^ cw[6] ^ cw[5] ^ cw[4];
    raw_d  = {cw[6], cw[5], cw[4], cw[2]};
    case (syn)
      3'b011:  fix_d = 4'b0001;
      3'b101:  fix_d = 4'b0010;
      3'b110:  fix_d = 4'b0100;
      3'b111:  fix_d = 4'b1000;
      default: fix_d = 4'b0000;
    endcase
`ifdef HAMMING74_RX_SECDED_EN
    dbl_d = (syn != 3'b000) && !(^sr_q);
    dec_d = dbl_d ? raw_d : (raw_d ^ fix_d);
    err_d = (syn != 3'b000) || (^sr_q);
`else
    dbl_d = 1'b0;
    dec_d = raw_d ^ fix_d;
    err_d = (syn != 3'b000);
`endif
    entry_d = {dec_d, raw_d, err_d, dbl_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE, DECODE: begin
          if (bit_valid && sync_in) begin
            sr_q    <= {{(FW-1){1'b0}}, bit_in};
            cnt_q   <= 4'd1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            if (sync_in) begin
              // A new marker mid-frame abandons the partial word and restarts on this bit.
              frame_err_q <= 1'b1;
              sr_q        <= {{(FW-1){1'b0}}, bit_in};
              cnt_q       <= 4'd1;
            end else begin
              sr_q  <= {sr_q[FW-2:0], bit_in};
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'(FW-1)) state_q <= DECODE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = (state_q == DECODE);
  assign pop   = !empty && data_ready;
  // When full, a push only lands if the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= entry_d;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else if (clr_stats) begin
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (push && (syn != 3'b000) && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_q <= err_cnt_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign head       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign data_out   = head[9:6];
  assign raw_out    = head[5:2];
  assign err_flag   = head[1];
`ifdef HAMMING74_RX_SECDED_EN
  assign dbl_err    = head[0];
`else
  assign dbl_err    = 1'b0 & head[0];
`endif
  assign data_valid = !empty;
  assign err_count  = err_cnt_q;
  assign overflow   = ovf_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hamming74_serial_rx.sv
// Bench for hamming74_serial_rx (default 7-bit build): directed codewords, expected entries queued
// by the driver and popped by a monitor on every accepted FIFO head.
module tb_hamming74_serial_rx;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 8;
  localparam int EW         = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_in, bit_valid, sync_in;
  logic [3:0]       data_out, raw_out;
  logic             err_flag, dbl_err, data_valid, data_ready;
  logic [CNT_W-1:0] err_count;
  logic             overflow, frame_err, clr_stats, busy;

  hamming74_serial_rx #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync_in(sync_in),
    .data_out(data_out), .raw_out(raw_out), .err_flag(err_flag), .dbl_err(dbl_err),
    .data_valid(data_valid), .data_ready(data_ready), .err_count(err_count),
    .overflow(overflow), .frame_err(frame_err), .clr_stats(clr_stats), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int fe0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: compare every entry the consumer accepts
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (data_valid === 1'b1 && data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h, expected no entry", {data_out, raw_out, err_flag, dbl_err});
      end else begin
        exp_e = exp_q.pop_front();
        check("entry", {22'd0, data_out, raw_out, err_flag, dbl_err}, {22'd0, exp_e});
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [6:0] cw, input int nbits);
    for (int i = 6; i > 6 - nbits; i--) begin
      bit_in    = cw[i];
      bit_valid = 1'b1;
      sync_in   = (i == 6);
      tick(1);
    end
    bit_valid = 1'b0;
    sync_in   = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic expect_entry(input logic [3:0] d, input logic [3:0] r, input logic e);
    exp_q.push_back({d, r, e, 1'b0});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      tick(1);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sync_in = 1'b0;
    data_ready = 1'b1; clr_stats = 1'b0;
    tick(3);
    check("rst_outputs", {data_out, raw_out, err_flag, dbl_err, data_valid, overflow, frame_err, busy}, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    tick(2);

    // clean 4'hB, data_valid exactly one cycle from E+1
    expect_entry(4'hB, 4'hB, 1'b0);
    send(7'b1010101, 7);
    check("t1_busy_decode", busy, 1);
    check("t1_dv_at_E", data_valid, 0);
    tick(1);
    check("t1_dv_at_E1", data_valid, 1);
    tick(1);
    check("t1_dv_at_E2", data_valid, 0);
    check("t1_err_count", err_count, 0);
    check("t1_busy_idle", busy, 0);

    // c4 flipped -> syndrome 101
    expect_entry(4'hB, 4'h9, 1'b1);
    send(7'b1000101, 7);
    tick(2);
    check("t2_err_count", err_count, 1);

    // c1 flipped -> parity-only error
    expect_entry(4'hB, 4'hB, 1'b1);
    send(7'b1010111, 7);
    tick(2);
    check("t3_err_count", err_count, 2);

    // overflow: five clean words into a 4-deep stalled FIFO
    data_ready = 1'b0;
    expect_entry(4'h1, 4'h1, 1'b0); send(7'b0000111, 7);
    expect_entry(4'h2, 4'h2, 1'b0); send(7'b0011001, 7);
    expect_entry(4'h3, 4'h3, 1'b0); send(7'b0011110, 7);
    expect_entry(4'h4, 4'h4, 1'b0); send(7'b0101010, 7);
    send(7'b0101101, 7);
    tick(2);
    check("t4_overflow", overflow, 1);
    check("t4_dv_stalled", data_valid, 1);
    check("t4_head_stalled", {data_out, raw_out, err_flag}, {4'h1, 4'h1, 1'b0});
    tick(3);
    check("t4_head_stable", {data_out, raw_out, err_flag}, {4'h1, 4'h1, 1'b0});
    check("t4_err_count", err_count, 2);
    data_ready = 1'b1;
    drain();
    check("t4_dv_empty", data_valid, 0);
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    check("t4_clr_overflow", overflow, 0);
    check("t4_clr_err_count", err_count, 0);

    // partial frame interrupted by a new marker
    fe0 = fe_cnt;
    send(7'b1010101, 3);
    expect_entry(4'hB, 4'hB, 1'b0);
    send(7'b1010101, 7);
    tick(3);
    check("t5_frame_err_pulses", fe_cnt - fe0, 1);
    drain();

    // saturation of err_count
    for (int k = 0; k < (1 << CNT_W) + 2; k++) begin
      expect_entry(4'hB, 4'h9, 1'b1);
      send(7'b1000101, 7);
    end
    drain();
    check("t6_err_count_sat", err_count, {CNT_W{1'b1}});

    // reset mid-frame
    fe0 = fe_cnt;
    send(7'b1010101, 3);
    rst = 1'b1;
    #2;
    check("t7_rst_outputs", {data_out, raw_out, err_flag, dbl_err, data_valid, overflow, frame_err, busy}, 0);
    check("t7_rst_err_count", err_count, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    expect_entry(4'hB, 4'hB, 1'b0);
    send(7'b1010101, 7);
    drain();
    check("t7_no_frame_err", fe_cnt - fe0, 0);
    check("t7_err_count", err_count, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming74_serial_rx.md
Name: hamming74_serial_rx

Overview:
- Serial receive end of the Hamming(7,4) link.
- Deserialises a bitstream of 7-bit codewords delimited by a start marker, then computes the syndrome and corrects any single-bit error.
- Buffers the decoded nibbles in a small FIFO behind a valid/ready interface.
- Keeps error statistics for the link monitor.

Parameters:
- FIFO_DEPTH, 4, output buffer entries (power of 2, at least 2).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bit_in  in  1  serial codeword bit.
- bit_valid  in  1  bit_in is sampled on this edge.
- sync_in  in  1  qualified by bit_valid; marks the bit as codeword bit 6, i.e. the first bit.
- data_out  out  4  corrected nibble {d3,d2,d1,d0} at the FIFO head.
- raw_out  out  4  uncorrected nibble {c6,c5,c4,c2} at the FIFO head.
- err_flag  out  1  FIFO-head entry had a nonzero syndrome.
- dbl_err  out  1  FIFO-head entry is uncorrectable. Only driven with the optional feature; otherwise tied 0.
- data_valid  out  1  FIFO not empty.
- data_ready  in  1  consumer accepts the head entry.
- err_count  out  CNT_W  saturating count of nonzero-syndrome codewords.
- overflow  out  1  sticky: a decoded word was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: a partial frame was discarded.
- clr_stats  in  1  synchronous clear of err_count and overflow.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, bit counter 0.
- Codeword layout, bits arriving MSB-first (c6 first, c0 last):
  - c6 = d3, c5 = d2, c4 = d1, c3 = p2, c2 = d0, c1 = p1, c0 = p0.
- Syndrome:
  - s0 = c0^c6^c4^c2
  - s1 = c1^c6^c5^c2
  - s2 = c3^c6^c5^c4
- Correction by syndrome {s2,s1,s0}:
  - 011 flips d0; 101 flips d1; 110 flips d2; 111 flips d3.
  - 001, 010, 100 are parity-bit errors: data unchanged, err_flag still set.
- State machine:
  - IDLE: bit_valid & sync_in shifts the bit in, counter=1, go to SHIFT. bit_valid without sync_in is ignored silently.
  - SHIFT: each bit_valid shifts in and increments the counter. bit_valid & sync_in before the frame is complete discards the partial frame, pulses frame_err, and starts a new frame with this bit (counter=1). Accepting the 7th bit goes to DECODE.
  - DECODE, one cycle: computes the syndrome and corrects the data. The entry {data, raw, err, dbl} is pushed at the closing edge. Incoming bit_valid in this cycle is handled exactly as in IDLE, so the next state is SHIFT if sync_in is set, otherwise IDLE.
- Latency: with the 7th bit sampled at edge E, the FIFO is written at edge E+1 and data_valid is high from E+1 if the FIFO was empty.
- Handshake:
  - The head entry is popped on edge with data_valid & data_ready.
  - Outputs stay stable while data_valid & !data_ready.
  - data_ready is ignored while the FIFO is empty.
- FIFO boundaries:
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged.
  - Push while full without pop: entry dropped, overflow set. err_count still increments if the syndrome is nonzero.
  - Pointers wrap modulo FIFO_DEPTH.
- err_count:
  - Increments on the push cycle when the syndrome is nonzero.
  - Saturates at all-ones.
  - clr_stats has priority over a simultaneous increment or overflow set.
- Reset mid-frame: the partial frame and FIFO contents are lost and no frame_err is raised.

Optional Feature:
- Macro: HAMMING74_RX_SECDED_EN.
- Defined:
  - Codewords are 8 bits: an overall even-parity bit c7 (XOR of c0..c6) arrives after c0.
  - The frame closes on the 8th bit.
  - Nonzero syndrome with correct overall parity: uncorrectable. data_out = raw, dbl_err=1, err_flag=1.
  - Zero syndrome with wrong overall parity: c7 error. Data unchanged, err_flag=1.
  - Nonzero syndrome with wrong overall parity: corrected as above.
- Undefined: 7-bit frames, dbl_err constant 0.

Test Plan:
- Send 7'b1010101 (nibble 4'hB) with sync on the first bit, ready=1 -> data_out=4'hB, raw_out=4'hB, err_flag=0, err_count=0, data_valid high for exactly one cycle starting at E+1.
- Send 7'b1000101 (c4 flipped) -> syndrome 101, data_out=4'hB, raw_out=4'h9, err_flag=1, err_count=1.
- Send 7'b1010111 (c1 flipped) -> data_out=4'hB, raw_out=4'hB, err_flag=1, err_count increments.
- data_ready=0, send 5 clean codewords (nibbles 1,2,3,4,5) with FIFO_DEPTH=4 -> overflow=1 after the 5th; with ready=1, drains 1,2,3,4 in order, then data_valid=0. Then clr_stats -> overflow=0, err_count=0.
- Send 3 bits, then a sync-marked bit starting the full 7'b1010101 -> one frame_err pulse, a single entry 4'hB output.
- Force 2^CNT_W+2 single-error codewords -> err_count holds at all-ones. Assert rst mid-frame -> all outputs 0, the next clean frame decodes correctly.
